// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first subtractor computing A - B - Bin over WIDTH cycles
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic             bor;
  logic             a, b, d, bor_nx;
  logic             last;
  // one-bit subtract stage fed from the low end of the operand shift registers
  always_comb begin
    a      = a_sr[0];
    b      = b_sr[0];
    d      = a ^ b ^ bor;
    bor_nx = (~a & b) | (~(a ^ b) & bor);
    last   = cnt == CW'(WIDTH - 1);
  end
  // control FSM, datapath shifting and result capture; the MSB stage's a and d give the overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      bor   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          a_sr  <= A;
          b_sr  <= B;
          bor   <= Bin;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= {d, d_sr[WIDTH-1:1]};
          bor  <= bor_nx;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            D     <= {d, d_sr[WIDTH-1:1]};
            Bout  <= bor_nx;
            ovf   <= (a ^ b) & (d ^ a);
          end else
            cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
